// File: rtl/muldiv_controller.sv
// muldiv_controller: runs one MULT or DIV at a time on the shared HI/LO path,
// with divide-by-zero screening, abort and a run-cycle watchdog.
module muldiv_controller #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        op,
   input  logic [31:0] b_operand,
   input  logic        abort,
   input  logic        mult_done,
   input  logic        div_done,
   output logic        mult_on,
   output logic        div_on,
   output logic        hi_src,
   output logic        lo_src,
   output logic        hi_write,
   output logic        lo_write,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic        timeout,
   output logic [7:0]  cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_WRITE,
      S_ZERO,
      S_FAULT
   } state_t;

   localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       op_q, op_d;
   logic       src_q, src_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cyc_q, cyc_d;
   logic       sel_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         src_q   <= 1'b0;
         cnt_q   <= 8'd0;
         cyc_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src_d    = src_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      mult_on  = 1'b0;
      div_on   = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      done     = 1'b0;
      div_zero = 1'b0;
      timeout  = 1'b0;
      // the idle unit's completion flag never counts
      sel_done = op_q ? div_done : mult_done;
      unique case (state_q)
         S_IDLE: begin
            if (req && !abort) begin
               if (op && b_operand == 32'd0) begin
                  state_d = S_ZERO;
               end else begin
                  state_d = S_RUN;
                  op_d    = op;
                  src_d   = ~op;
                  cnt_d   = 8'd0;
               end
            end
         end
         S_RUN: begin
            mult_on = ~op_q;
            div_on  = op_q;
            if (abort) begin
               state_d = S_IDLE;
            end else if (sel_done) begin
               state_d = S_WRITE;
               cyc_d   = cnt_q + 8'd1;
            end else if (cnt_q == RUN_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WRITE: begin
            state_d  = S_IDLE;
            hi_write = ~abort;
            lo_write = ~abort;
            done     = ~abort;
         end
         S_ZERO: begin
            state_d  = S_IDLE;
            div_zero = ~abort;
         end
         S_FAULT: begin
            state_d = S_IDLE;
            timeout = ~abort;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign hi_src = src_q;
   assign lo_src = src_q;
   assign cycles = cyc_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller: directed vector table plus hand sequences
// for abort, reset and ignored-request corner cases.
module tb_muldiv_controller;

   logic        clk;
   logic        reset;
   logic        req;
   logic        op;
   logic [31:0] b_operand;
   logic        abort;
   logic        mult_done;
   logic        div_done;
   logic        mult_on;
   logic        div_on;
   logic        hi_src;
   logic        lo_src;
   logic        hi_write;
   logic        lo_write;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        timeout;
   logic [7:0]  cycles;

   int total = 0;
   int bad   = 0;

   muldiv_controller #(.TIMEOUT(40)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .op        (op),
      .b_operand (b_operand),
      .abort     (abort),
      .mult_done (mult_done),
      .div_done  (div_done),
      .mult_on   (mult_on),
      .div_on    (div_on),
      .hi_src    (hi_src),
      .lo_src    (lo_src),
      .hi_write  (hi_write),
      .lo_write  (lo_write),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .timeout   (timeout),
      .cycles    (cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          op;
      logic [31:0] b;
      int          done_at;
      int          stray_at;
      int          e_busy;
      int          e_mon;
      int          e_don;
      int          e_wr;
      int          e_dz;
      int          e_to;
      int          e_cyc;
      bit          e_src;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int bn, mon, don, hw, lw, dn, dz, to, r, guard;
      bn = 0; mon = 0; don = 0; hw = 0; lw = 0;
      dn = 0; dz = 0; to = 0; r = 0; guard = 0;
      @(negedge clk);
      req = 1'b1;
      op = v.op;
      b_operand = v.b;
      @(negedge clk);
      req = 1'b0;
      while (busy && guard < 300) begin
         bn++;
         mon += int'(mult_on);
         don += int'(div_on);
         hw  += int'(hi_write);
         lw  += int'(lo_write);
         dn  += int'(done);
         dz  += int'(div_zero);
         to  += int'(timeout);
         mult_done = 1'b0;
         div_done  = 1'b0;
         if (mult_on || div_on) begin
            if (v.op) begin
               div_done  = (r == v.done_at);
               mult_done = (r == v.stray_at);
            end else begin
               mult_done = (r == v.done_at);
               div_done  = (r == v.stray_at);
            end
            r++;
         end
         @(negedge clk);
         guard++;
      end
      mult_done = 1'b0;
      div_done  = 1'b0;
      if (guard >= 300) chk($sformatf("v%0d_busy_bound", idx), guard, 0);
      chk($sformatf("v%0d_busy_len", idx), bn, v.e_busy);
      chk($sformatf("v%0d_mult_on", idx), mon, v.e_mon);
      chk($sformatf("v%0d_div_on", idx), don, v.e_don);
      chk($sformatf("v%0d_hi_write", idx), hw, v.e_wr);
      chk($sformatf("v%0d_lo_write", idx), lw, v.e_wr);
      chk($sformatf("v%0d_done", idx), dn, v.e_wr);
      chk($sformatf("v%0d_div_zero", idx), dz, v.e_dz);
      chk($sformatf("v%0d_timeout", idx), to, v.e_to);
      chk($sformatf("v%0d_cycles", idx), int'(cycles), v.e_cyc);
      chk($sformatf("v%0d_hi_src", idx), int'(hi_src), int'(v.e_src));
      chk($sformatf("v%0d_lo_src", idx), int'(lo_src), int'(v.e_src));
   endtask

   task automatic accept(input bit o, input logic [31:0] b);
      @(negedge clk);
      req = 1'b1;
      op = o;
      b_operand = b;
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      int dn, r, guard, pulses;
      // op, b, done_at, stray_at, busy, mon, don, wr, dz, to, cyc, src
      vecs[0] = '{1'b0, 32'd7, 33, -1, 35, 34, 0, 1, 0, 0, 34, 1'b1};
      vecs[1] = '{1'b1, 32'd3, 31, 5, 33, 0, 32, 1, 0, 0, 32, 1'b0};
      vecs[2] = '{1'b1, 32'd0, -1, -1, 1, 0, 0, 0, 1, 0, 32, 1'b0};
      vecs[3] = '{1'b0, 32'd9, -1, -1, 41, 40, 0, 0, 0, 1, 32, 1'b1};
      vecs[4] = '{1'b1, 32'd0, -1, -1, 1, 0, 0, 0, 1, 0, 32, 1'b1};
      vecs[5] = '{1'b1, 32'd1, 39, -1, 41, 0, 40, 1, 0, 0, 40, 1'b0};
      vecs[6] = '{1'b0, 32'd0, 0, 0, 2, 1, 0, 1, 0, 0, 1, 1'b1};
      vecs[7] = '{1'b1, 32'hFFFF_FFFF, 0, -1, 2, 0, 1, 1, 0, 0, 1, 1'b0};

      reset = 1'b0;
      req = 1'b0;
      op = 1'b0;
      b_operand = 32'd0;
      abort = 1'b0;
      mult_done = 1'b0;
      div_done = 1'b0;
      #12;
      chk("reset_outs", int'({mult_on, div_on, hi_src, lo_src, hi_write,
          lo_write, busy, done, div_zero, timeout, cycles}), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // abort in RUN cycle 10 of a DIV
      accept(1'b1, 32'd5);
      pulses = 0;
      repeat (10) begin
         pulses += int'(hi_write) + int'(done);
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_run_busy", int'(busy), 0);
      chk("abort_run_div_on", int'(div_on), 0);
      chk("abort_run_pulses", pulses + int'(hi_write) + int'(done), 0);

      // abort together with the selected done
      accept(1'b1, 32'd5);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      div_done = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      div_done = 1'b0;
      chk("abort_done_busy", int'(busy), 0);
      chk("abort_done_write", int'(hi_write | lo_write | done), 0);
      chk("abort_done_cycles", int'(cycles), 1);

      // abort in WRITE suppresses the pulses
      accept(1'b0, 32'd5);
      mult_done = 1'b1;
      @(negedge clk);
      mult_done = 1'b0;
      abort = 1'b1;
      #1;
      chk("abort_write_pulse", int'(hi_write | lo_write | done), 0);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_write_busy", int'(busy), 0);

      // abort in IDLE blocks acceptance
      @(negedge clk);
      req = 1'b1;
      op = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      req = 1'b0;
      abort = 1'b0;
      chk("abort_idle_busy", int'(busy), 0);

      // asynchronous reset mid-RUN
      accept(1'b1, 32'd2);
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("reset_mid_outs", int'({mult_on, div_on, hi_src, lo_src, hi_write,
          lo_write, busy, done, div_zero, timeout, cycles}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_mid_idle", int'(busy), 0);

      // req while busy is ignored
      accept(1'b0, 32'd7);
      dn = 0;
      r = 0;
      guard = 0;
      while (busy && guard < 100) begin
         dn += int'(done);
         mult_done = (r == 5);
         req = (r == 2);
         r++;
         @(negedge clk);
         guard++;
      end
      req = 1'b0;
      mult_done = 1'b0;
      chk("ignored_req_done", dn, 1);
      chk("ignored_req_cycles", int'(cycles), 6);
      @(negedge clk);
      chk("ignored_req_idle", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_controller.md
# muldiv_controller

Sequencer that shares the HI/LO result path between the multiplier and the divider and runs one MULT or DIV operation at a time for the main control unit. It accepts a request, enables the selected unit, waits for its completion flag, then steers the Hi/Lo source muxes and pulses the Hi/Lo register write enables. It detects divide-by-zero before the divider is started and raises a timeout if a unit never completes. It sits between `control_unit` and the `multiplier`, `divider`, `mux_Hi_src` and `mux_Lo_src` instances in `cpu`.

## Interface
- TIMEOUT, 40, run-cycle limit before fault; legal range 2..255.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  operation request from the control unit; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with req.
- b_operand  in  32  divisor value (B register output); zero-checked when a DIV is accepted.
- abort  in  1  synchronous cancel of the current operation.
- mult_done  in  1  multiplier result valid.
- div_done  in  1  divider result valid.
- mult_on  out  1  multiplier enable; high throughout RUN when op = MULT.
- div_on  out  1  divider enable; high throughout RUN when op = DIV.
- hi_src  out  1  Hi mux select: 0 = divider, 1 = multiplier.
- lo_src  out  1  Lo mux select: 0 = divider, 1 = multiplier.
- hi_write  out  1  Hi register write pulse.
- lo_write  out  1  Lo register write pulse.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a result is written.
- div_zero  out  1  one-cycle exception pulse.
- timeout  out  1  one-cycle fault pulse.
- cycles  out  8  RUN-cycle count of the last completed operation.

## Operation
- The state machine has five states: IDLE, RUN, WRITE, ZERO and FAULT. The state is one-hot or binary; this is not observable outside the block.
- **IDLE**
  - If req is high, op = 1 and b_operand = 0: go to ZERO.
  - Otherwise, if req is high: go to RUN. The accept edge latches op into an internal register, sets hi_src = lo_src = ~op, and clears the run counter.
- **RUN**
  - mult_on or div_on follows the latched op. The other enable stays low.
  - The counter increments every RUN cycle.
  - Only the done flag of the selected unit is honoured. The other unit's done flag is ignored.
  - Selected done high: go to WRITE and latch cycles = counter + 1.
  - Counter equals TIMEOUT−1 with no done: go to FAULT.
- **WRITE**: hi_write, lo_write and done are all 1 for one cycle, then go to IDLE.
- **ZERO**: div_zero = 1 for one cycle. No write pulses; neither unit is enabled. Then go to IDLE.
- **FAULT**: timeout = 1 for one cycle. No write pulses; cycles is unchanged. Then go to IDLE.
- **Abort**: abort high in RUN, WRITE, ZERO or FAULT sends the block to IDLE on the next edge and suppresses that cycle's pulses. Abort in IDLE has no effect and blocks acceptance of req in that cycle.
- **Priority** within a cycle, highest first: abort, then done, then timeout.
- **Selects**: hi_src and lo_src hold their value from acceptance until the next accepted request; ZERO does not change them.
- **No queueing**: req while busy is ignored. The control unit must re-assert req after busy falls.
- **Counter**: 8 bits and never wraps, because TIMEOUT ≤ 255.

## Timing
- **Reset** (reset = 0, asynchronous): state goes to IDLE. Every output is 0, including hi_src, lo_src and cycles; the counter and latched op are also 0.
- **Accept**: on edge E0, req is sampled in IDLE. busy and the unit enable go high in the cycle after E0, which is RUN cycle 0.
- **Write latency**: if the selected done is high in RUN cycle k, hi_write, lo_write and done are high in the next cycle, and cycles = k+1. busy drops the cycle after that.
- **Minimum request-to-write latency**: 2 cycles (done present in RUN cycle 0).
- **Divide-by-zero**: div_zero is high in the cycle after acceptance. busy is high for exactly 1 cycle.
- **Timeout**: the timeout pulse is high in the cycle after RUN cycle TIMEOUT−1, so busy is high for TIMEOUT+1 cycles.
- **Back-to-back requests**: a new req can be accepted on the edge at which the block is in IDLE. The earliest acceptance is the cycle after the WRITE, ZERO or FAULT cycle.
- **Reset mid-operation**: returns immediately to the reset values. No write pulse is produced.

## Test plan
- **MULT**: req, op = 0, b = 7; mult_done asserted in RUN cycle 33 -> mult_on high for 34 cycles, hi_src = lo_src = 1, single hi_write/lo_write/done pulse, cycles = 34, div_on never high.
- **DIV**: req, op = 1, b = 3; div_done in RUN cycle 31, with mult_done pulsed in RUN cycle 5 -> mult_done ignored, write pulse after RUN cycle 31, hi_src = lo_src = 0, cycles = 32.
- **Divide-by-zero**: req, op = 1, b = 0 -> div_zero pulse 1 cycle after accept, no hi_write or lo_write, div_on never high, busy high for 1 cycle.
- **Timeout**: TIMEOUT = 40, MULT request, mult_done never asserted -> timeout pulse after RUN cycle 39, no write pulse, cycles keeps its previous value, then IDLE.
- **Abort precedence**: abort in RUN cycle 10 of a DIV -> IDLE next cycle, no pulses. Then abort and div_done high in the same cycle -> no write.
- **Reset and ignored request**: reset low mid-RUN -> all outputs 0 immediately. After recovery, req re-asserted while busy -> ignored, and only one done pulse results.
